refresh_scheduler: RTL and testbench
====================================

// Module: refresh_scheduler
// PURPOSE
//  Generates refresh_com for the mcu. Sequences SDRAM power-up (wait, then INIT_REFRESHES back-to-back
//  refreshes), then requests one auto-refresh every REF_INTERVAL cycles.
//  Postpones refreshes while the mcu is busy, up to MAX_PENDING owed refreshes.
//  Sits upstream of the mcu, beside bus_interface; init_done gates bus acceptance.
// PARAMETERS
//  INIT_CYCLES     10000  power-up wait in clk cycles (100us @ 100MHz); legal 1..2^20-1
//  INIT_REFRESHES  8      refreshes required before init_done; legal 1..15
//  REF_INTERVAL    780    cycles between refresh ticks (7.8us @ 100MHz); legal 2..2^16-1
//  MAX_PENDING     8      owed-refresh ceiling; legal 2..15
// PORTS
//  clk          in   1   system clock, rising edge
//  n_rst        in   1   synchronous reset, ACTIVE-HIGH (1 = reset), sampled on clk
//  idle         in   1   mcu idle; 1 = no transfer in progress
//  ref_ack      in   1   one-cycle pulse from mcu: refresh command issued
//  refresh_com  out  1   refresh request to mcu, level, held until ref_ack
//  init_done    out  1   1 once the power-up sequence completes; stays 1 until reset
//  urgent       out  1   pending >= MAX_PENDING-1; mcu must refresh before the next transfer
//  pending      out  4   owed refreshes in RUN, 0..MAX_PENDING
//  overflow     out  1   sticky; a tick arrived while pending == MAX_PENDING
// BEHAVIOUR
//  Reset (n_rst=1 at a clk edge): state=POWERUP, wait counter=0, interval counter=REF_INTERVAL-1,
//   pending=0, init count=0. All outputs 0 on the following cycle. Reset mid-operation aborts
//   everything; a held request is dropped without waiting for ref_ack.
//  FSM (registered state):
//   POWERUP: wait counter increments each cycle; at INIT_CYCLES-1 -> INIT_REF.
//            refresh_com=0. ref_ack is ignored.
//   INIT_REF: refresh_com=1 regardless of idle. Each ref_ack increments init count.
//            When init count reaches INIT_REFRESHES -> RUN. refresh_com drops the cycle after
//            the final ack. init_done=1 from the first RUN cycle.
//   RUN: interval counter counts down; at 0 it reloads REF_INTERVAL-1 and emits tick (1 cycle).
//            The first tick comes REF_INTERVAL cycles after entering RUN.
//  pending update in RUN, evaluated per cycle:
//   tick & ~ack_v -> +1, saturating at MAX_PENDING; tick at MAX_PENDING sets overflow
//   ~tick & ack_v -> -1
//   tick & ack_v  -> unchanged
//   ack_v = ref_ack & refresh_com (ack with no request is ignored; pending never underflows)
//  refresh_com (RUN) = registered; next value = (pending_next != 0) & (idle | urgent_next).
//   Once asserted, it stays high until ack_v, even if idle falls.
//   After ack_v, it reasserts the next cycle if pending is still nonzero and the condition holds.
//  urgent = (pending >= MAX_PENDING-1), registered with pending.
//  overflow clears only on reset.
//  Internal counter widths: 20b wait, 16b interval, 4b pending/init.
//  Latency: tick -> refresh_com high is 1 cycle (if idle). ref_ack -> pending decrement is 1 cycle.
// CONFIGURATION
//  REFRESH_SCHEDULER_STATS_EN defined: adds output ref_total [15:0]. It counts every ack_v
//   (INIT_REF and RUN), wraps 16'hFFFF -> 0, and resets to 0.
//   It also adds output max_pending [3:0], the high-water mark of pending since reset.
//  Not defined: neither port exists, no stats logic is built, all other behaviour is identical.
// TESTING (INIT_CYCLES=20, INIT_REFRESHES=2, REF_INTERVAL=10, MAX_PENDING=4)
//  Init sequence: reset, idle=1, ack 2 cycles after each request.
//   -> refresh_com rises at cycle 20; init_done=1 after the 2nd ack; pending=0.
//  Steady state: idle=1, mcu acks 1 cycle after each request.
//   -> one refresh_com per 10 cycles; pending never exceeds 1; overflow=0.
//  Postponement: idle=0, no acks, for 35 RUN cycles.
//   -> pending=3 and urgent=1 at the 3rd tick; refresh_com=1 at urgent despite idle=0.
//  Saturation: continue with no acks until the 5th tick.
//   -> pending holds 4; overflow=1 and stays 1 after 4 acks drain pending to 0.
//  Corner cases:
//   tick and ack_v in the same cycle -> pending unchanged.
//   ref_ack while refresh_com=0 -> ignored; pending stays 0.
//   Reset asserted mid-INIT_REF -> all outputs 0 the next cycle; full sequence restarts.
//  With REFRESH_SCHEDULER_STATS_EN: after init plus 3 RUN acks -> ref_total=5; max_pending = peak seen.

Source files
------------

// File: rtl/refresh_scheduler.sv
// SDRAM refresh scheduler: power-up wait, init refresh burst, then periodic auto-refresh
// with postponement. Optional stats outputs are built when REFRESH_SCHEDULER_STATS_EN is defined.
module refresh_scheduler #(
  parameter int INIT_CYCLES    = 10000,
  parameter int INIT_REFRESHES = 8,
  parameter int REF_INTERVAL   = 780,
  parameter int MAX_PENDING    = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        idle,
  input  logic        ref_ack,
  output logic        refresh_com,
  output logic        init_done,
  output logic        urgent,
  output logic [3:0]  pending,
  output logic        overflow
`ifdef REFRESH_SCHEDULER_STATS_EN
  ,
  output logic [15:0] ref_total,
  output logic [3:0]  max_pending
`endif
);

  typedef enum logic [1:0] {POWERUP, INIT_REF, RUN} state_t;

  localparam logic [19:0] WAIT_LAST = 20'(INIT_CYCLES - 1);
  localparam logic [15:0] IV_LAST   = 16'(REF_INTERVAL - 1);
  localparam logic [3:0]  INIT_N    = 4'(INIT_REFRESHES);
  localparam logic [3:0]  MAX_P     = 4'(MAX_PENDING);
  localparam logic [3:0]  URG_TH    = 4'(MAX_PENDING - 1);

  state_t      state_q;
  logic [19:0] wait_q;
  logic [15:0] interval_q;
  logic [3:0]  pending_q, pending_d;
  logic [3:0]  init_q;
  logic        refresh_q, refresh_d;
  logic        urgent_q, urgent_d;
  logic        init_done_q;
  logic        overflow_q;
  logic        ack_v, tick, overflow_set;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    ack_v        = ref_ack & refresh_q;
    tick         = (state_q == RUN) && (interval_q == '0);
    pending_d    = pending_q;
    overflow_set = 1'b0;
    if (tick && !ack_v) begin
      if (pending_q == MAX_P) overflow_set = 1'b1;
      else                    pending_d    = pending_q + 4'd1;
    end else if (!tick && ack_v && pending_q != '0) begin
      pending_d = pending_q - 4'd1;
    end
    urgent_d  = (pending_d >= URG_TH);
    // A raised request is held until acknowledged, even if the mcu stops being idle.
    refresh_d = (refresh_q & ~ack_v) | ((pending_d != '0) & (idle | urgent_d));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q     <= POWERUP;
      wait_q      <= '0;
      interval_q  <= IV_LAST;
      pending_q   <= '0;
      init_q      <= '0;
      refresh_q   <= 1'b0;
      urgent_q    <= 1'b0;
      init_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        POWERUP: begin
          if (wait_q == WAIT_LAST) begin
            state_q   <= INIT_REF;
            refresh_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 20'd1;
          end
        end
        INIT_REF: begin
          if (ack_v) begin
            init_q <= init_q + 4'd1;
            if (init_q + 4'd1 == INIT_N) begin
              state_q     <= RUN;
              refresh_q   <= 1'b0;
              init_done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          interval_q <= tick ? IV_LAST : interval_q - 16'd1;
          pending_q  <= pending_d;
          urgent_q   <= urgent_d;
          refresh_q  <= refresh_d;
          if (overflow_set) overflow_q <= 1'b1;
        end
        default: state_q <= POWERUP;
      endcase
    end
  end

  assign refresh_com = refresh_q;
  assign init_done   = init_done_q;
  assign urgent      = urgent_q;
  assign pending     = pending_q;
  assign overflow    = overflow_q;

`ifdef REFRESH_SCHEDULER_STATS_EN
  logic [15:0] ref_total_q;
  logic [3:0]  max_pending_q;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      ref_total_q   <= '0;
      max_pending_q <= '0;
    end else begin
      if (ack_v) ref_total_q <= ref_total_q + 16'd1;
      if (pending_q > max_pending_q) max_pending_q <= pending_q;
    end
  end

  assign ref_total   = ref_total_q;
  assign max_pending = max_pending_q;
`endif

endmodule

// File: tb/tb_refresh_scheduler.sv
// Self-checking bench for refresh_scheduler: vector tables and cycle loops with hand-derived
// expectations fed through an expected-output queue. Stats checks apply when the stats macro is defined.
module tb_refresh_scheduler;

  typedef struct packed {
    logic       rc;
    logic       done;
    logic       urg;
    logic [3:0] pend;
    logic       ovf;
  } out_t;

  typedef struct packed {
    logic idle;
    logic ack;
    out_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       n_rst, idle, ref_ack;
  logic       refresh_com, init_done, urgent, overflow;
  logic [3:0] pending;
`ifdef REFRESH_SCHEDULER_STATS_EN
  logic [15:0] ref_total;
  logic [3:0]  max_pending;
`endif

  int   errors = 0;
  int   checks = 0;
  out_t exp_q[$];

  always #5 clk = ~clk;

  refresh_scheduler #(
    .INIT_CYCLES(20), .INIT_REFRESHES(2), .REF_INTERVAL(10), .MAX_PENDING(4)
  ) dut (
    .clk(clk), .n_rst(n_rst), .idle(idle), .ref_ack(ref_ack),
    .refresh_com(refresh_com), .init_done(init_done), .urgent(urgent),
    .pending(pending), .overflow(overflow)
`ifdef REFRESH_SCHEDULER_STATS_EN
    , .ref_total(ref_total), .max_pending(max_pending)
`endif
  );

  function automatic out_t o(logic rc, logic done, logic urg, logic [3:0] pend, logic ovf);
    return '{rc: rc, done: done, urg: urg, pend: pend, ovf: ovf};
  endfunction

  function automatic vec_t v(logic i_idle, logic i_ack, out_t e);
    return '{idle: i_idle, ack: i_ack, exp: e};
  endfunction

  // Drive one cycle of inputs, queue the expected outputs, then compare after the edge.
  task automatic step(input logic i_idle, input logic i_ack, input out_t e, input string name);
    out_t got, want;
    exp_q.push_back(e);
    idle    = i_idle;
    ref_ack = i_ack;
    @(posedge clk);
    #1;
    got  = '{rc: refresh_com, done: init_done, urg: urgent, pend: pending, ovf: overflow};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got rc=%b done=%b urg=%b pend=%0d ovf=%b, want rc=%b done=%b urg=%b pend=%0d ovf=%b",
               name, got.rc, got.done, got.urg, got.pend, got.ovf,
               want.rc, want.done, want.urg, want.pend, want.ovf);
    end
  endtask

  task automatic check16(input logic [15:0] got, input logic [15:0] want, input string name);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // From reset release: cycles 1..19 all outputs low, request rises at cycle 20.
  task automatic powerup(input logic toggle_ack);
    for (int c = 1; c <= 19; c++)
      step(1'b1, toggle_ack & c[0], o(0, 0, 0, 0, 0), $sformatf("powerup_c%0d", c));
    step(1'b1, 1'b0, o(1, 0, 0, 0, 0), "init_req_c20");
  endtask

  vec_t init_tbl  [6];
  vec_t drain_tbl [5];

  initial begin
    // Init: ack two cycles after each request; RUN is entered at cycle 26.
    init_tbl[0] = v(1, 0, o(1, 0, 0, 0, 0));
    init_tbl[1] = v(1, 0, o(1, 0, 0, 0, 0));
    init_tbl[2] = v(1, 1, o(1, 0, 0, 0, 0));
    init_tbl[3] = v(1, 0, o(1, 0, 0, 0, 0));
    init_tbl[4] = v(1, 0, o(1, 0, 0, 0, 0));
    init_tbl[5] = v(1, 1, o(0, 1, 0, 0, 0));
    // Drain a saturated backlog with idle=1; overflow must stay set.
    drain_tbl[0] = v(1, 1, o(1, 1, 1, 3, 1));
    drain_tbl[1] = v(1, 1, o(1, 1, 0, 2, 1));
    drain_tbl[2] = v(1, 1, o(1, 1, 0, 1, 1));
    drain_tbl[3] = v(1, 1, o(0, 1, 0, 0, 1));
    drain_tbl[4] = v(1, 0, o(0, 1, 0, 0, 1));

    n_rst = 1'b1; idle = 1'b1; ref_ack = 1'b0;
    step(1'b1, 1'b0, o(0, 0, 0, 0, 0), "reset_0");
    step(1'b1, 1'b0, o(0, 0, 0, 0, 0), "reset_1");
    n_rst = 1'b0;

    powerup(1'b0);
    for (int i = 0; i < 6; i++)
      step(init_tbl[i].idle, init_tbl[i].ack, init_tbl[i].exp, $sformatf("init_%0d", i));

    // Steady state from cycle 26: ticks at 35/45/55, ack one cycle after each request.
    for (int j = 1; j <= 30; j++) begin
      automatic int  ph  = j % 10;
      automatic bit  req = (j >= 10) && (ph <= 1);
      step(1'b1, (j >= 10) && (ph == 2), o(req, 1, 0, req ? 4'd1 : 4'd0, 0),
           $sformatf("steady_c%0d", 26 + j));
    end

    // Hold the request unacked until the next tick at cycle 65, then ack on the tick.
    for (int c = 57; c <= 65; c++)
      step(1'b1, 1'b0, o(1, 1, 0, 1, 0), $sformatf("hold_c%0d", c));
    step(1'b1, 1'b1, o(1, 1, 0, 1, 0), "tick_and_ack");
    step(1'b1, 1'b1, o(0, 1, 0, 0, 0), "ack_decrement");
    step(1'b1, 1'b1, o(0, 1, 0, 0, 0), "ack_without_request");
`ifdef REFRESH_SCHEDULER_STATS_EN
    check16(ref_total, 16'd6, "ref_total_after_run_acks");
`endif

    // Postponement and saturation: idle=0, no acks; ticks at 75,85,95,105,115.
    for (int c = 69; c <= 116; c++) begin
      automatic int n = (c - 66) / 10;
      automatic int p = (n > 4) ? 4 : n;
      step(1'b0, 1'b0, o(p >= 3, 1, p >= 3, 4'(p), n >= 5), $sformatf("postpone_c%0d", c));
    end

    for (int i = 0; i < 5; i++)
      step(drain_tbl[i].idle, drain_tbl[i].ack, drain_tbl[i].exp, $sformatf("drain_%0d", i));
`ifdef REFRESH_SCHEDULER_STATS_EN
    check16(ref_total, 16'd10, "ref_total_after_drain");
    check16({12'd0, max_pending}, 16'd4, "max_pending_peak");
`endif

    // Full restart with acks ignored during power-up, then reset in the middle of INIT_REF.
    n_rst = 1'b1;
    step(1'b1, 1'b0, o(0, 0, 0, 0, 0), "reset_from_run");
    n_rst = 1'b0;
    powerup(1'b1);
    step(1'b1, 1'b0, o(1, 0, 0, 0, 0), "init_hold_c21");
    n_rst = 1'b1;
    step(1'b1, 1'b0, o(0, 0, 0, 0, 0), "reset_mid_init");
`ifdef REFRESH_SCHEDULER_STATS_EN
    check16(ref_total, 16'd0, "ref_total_reset");
    check16({12'd0, max_pending}, 16'd0, "max_pending_reset");
`endif
    n_rst = 1'b0;
    powerup(1'b0);
    step(1'b1, 1'b1, o(1, 0, 0, 0, 0), "reinit_ack1");
    step(1'b1, 1'b1, o(0, 1, 0, 0, 0), "reinit_ack2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
